// File: rtl/ddr_wb_pkg.sv
// Shared constants and FSM state type for the DDR write line packer.
package ddr_wb_pkg;

  localparam int unsigned WORD_WIDTH      = 64;
  localparam int unsigned LINE_WIDTH      = 576;
  localparam int unsigned WORDS_PER_LINE  = LINE_WIDTH / WORD_WIDTH;
  localparam int unsigned BRAM_ADDR_WIDTH = 5;
  localparam int unsigned DEPTH           = 2 ** BRAM_ADDR_WIDTH;
  localparam int unsigned WCNT_WIDTH      = $clog2(WORDS_PER_LINE);
  localparam int unsigned CNT_WIDTH       = BRAM_ADDR_WIDTH + 1;

  typedef enum logic [0:0] {
    FILL       = 1'b0,
    FLUSH_DONE = 1'b1
  } pk_state_e;

endpackage

// File: rtl/line_credit_counter.sv
// Tracks BRAM line reservations (occ) and committed readable lines (lines_avail).
module line_credit_counter
  import ddr_wb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_wr_issue,
  input  logic                 i_wr_commit,
  input  logic                 i_rd_done,
  output logic                 o_full_c,
  output logic [CNT_WIDTH-1:0] o_lines_avail,
  output logic                 o_rd_underflow_err
);

  logic [CNT_WIDTH-1:0] r_occ;
  logic [CNT_WIDTH-1:0] r_lines_avail;
  logic                 r_underflow;
  logic                 w_rd_valid;

  // A read only counts when a committed line is actually resident.
  assign w_rd_valid         = i_rd_done && (r_lines_avail != '0);
  assign o_full_c           = (r_occ == CNT_WIDTH'(DEPTH));
  assign o_lines_avail      = r_lines_avail;
  assign o_rd_underflow_err = r_underflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ         <= '0;
      r_lines_avail <= '0;
      r_underflow   <= 1'b0;
    end else begin
      case ({i_wr_issue, w_rd_valid})
        2'b10:   r_occ <= r_occ + CNT_WIDTH'(1);
        2'b01:   r_occ <= r_occ - CNT_WIDTH'(1);
        default: r_occ <= r_occ;
      endcase
      case ({i_wr_commit, w_rd_valid})
        2'b10:   r_lines_avail <= r_lines_avail + CNT_WIDTH'(1);
        2'b01:   r_lines_avail <= r_lines_avail - CNT_WIDTH'(1);
        default: r_lines_avail <= r_lines_avail;
      endcase
      if (i_rd_done && (r_lines_avail == '0)) begin
        r_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_wr_line_packer.sv
// Packs accumulator words into DDR4 lines and writes them to the write BRAM,
// throttled by line credits so unread lines are never overwritten.
module ddr_wr_line_packer
  import ddr_wb_pkg::*;
(
  input  logic                       c0_ddr4_ui_clk,
  input  logic                       c0_ddr4_aresetn,
  input  logic [WORD_WIDTH-1:0]      s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       flush,
  output logic                       flush_done,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_wr_addr,
  output logic [LINE_WIDTH-1:0]      bram_wr_din,
  output logic                       bram_wr_en,
  output logic                       bram_wr_we,
  input  logic                       line_rd_done,
  output logic [CNT_WIDTH-1:0]       lines_avail,
  output logic                       rd_underflow_err
);

  pk_state_e                  r_state;
  logic [WCNT_WIDTH-1:0]      r_word_cnt;
  logic [LINE_WIDTH-1:0]      r_line;
  logic [BRAM_ADDR_WIDTH-1:0] r_wr_ptr;
  logic [BRAM_ADDR_WIDTH-1:0] r_wr_addr;
  logic [LINE_WIDTH-1:0]      r_wr_din;
  logic                       r_wr_en;
  logic                       r_flush_done;
  logic                       r_live;

  logic                       w_full;
  logic                       w_accept;
  logic                       w_last;
  logic                       w_flush_fire;
  logic                       w_wr_issue;
  logic [WCNT_WIDTH-1:0]      w_cnt_inc;
  logic [LINE_WIDTH-1:0]      w_line_next;

  // r_live keeps s_ready low while reset is held so every output reads 0.
  assign s_ready      = r_live && (r_state == FILL) && !w_full;
  assign w_accept     = s_valid && s_ready;
  assign w_cnt_inc    = r_word_cnt + WCNT_WIDTH'(w_accept);
  assign w_last       = w_accept && (r_word_cnt == WCNT_WIDTH'(WORDS_PER_LINE - 1));
  assign w_flush_fire = flush && (r_state == FILL);
  assign w_wr_issue   = w_last || (w_flush_fire && (w_cnt_inc != '0));

  assign bram_wr_addr = r_wr_addr;
  assign bram_wr_din  = r_wr_din;
  assign bram_wr_en   = r_wr_en;
  assign bram_wr_we   = r_wr_en;
  assign flush_done   = r_flush_done;

  // Line register with the word accepted this cycle merged in at word_cnt.
  always_comb begin
    w_line_next = r_line;
    for (int unsigned k = 0; k < WORDS_PER_LINE; k++) begin
      if (w_accept && (r_word_cnt == WCNT_WIDTH'(k))) begin
        w_line_next[k*WORD_WIDTH +: WORD_WIDTH] = s_data;
      end
    end
  end

  // Packer FSM, line register and BRAM write port.
  always_ff @(posedge c0_ddr4_ui_clk or negedge c0_ddr4_aresetn) begin
    if (!c0_ddr4_aresetn) begin
      r_state      <= FILL;
      r_word_cnt   <= '0;
      r_line       <= '0;
      r_wr_ptr     <= '0;
      r_wr_addr    <= '0;
      r_wr_din     <= '0;
      r_wr_en      <= 1'b0;
      r_flush_done <= 1'b0;
      r_live       <= 1'b0;
    end else begin
      r_live       <= 1'b1;
      r_wr_en      <= w_wr_issue;
      r_flush_done <= 1'b0;
      if (w_wr_issue) begin
        r_wr_din   <= w_line_next;
        r_wr_addr  <= r_wr_ptr;
        r_wr_ptr   <= r_wr_ptr + BRAM_ADDR_WIDTH'(1);
        r_word_cnt <= '0;
        r_line     <= '0;
      end else if (w_accept) begin
        r_line     <= w_line_next;
        r_word_cnt <= w_cnt_inc;
      end
      case (r_state)
        FILL: begin
          if (flush) begin
            r_state      <= FLUSH_DONE;
            r_flush_done <= 1'b1;
            r_word_cnt   <= '0;
          end
        end
        FLUSH_DONE: r_state <= FILL;
        default:    r_state <= FILL;
      endcase
    end
  end

  line_credit_counter u_credit (
    .clk                (c0_ddr4_ui_clk),
    .rst_n              (c0_ddr4_aresetn),
    .i_wr_issue         (w_wr_issue),
    .i_wr_commit        (r_wr_en),
    .i_rd_done          (line_rd_done),
    .o_full_c           (w_full),
    .o_lines_avail      (lines_avail),
    .o_rd_underflow_err (rd_underflow_err)
  );

endmodule

// File: tb/tb_ddr_wr_line_packer.sv
// Scoreboard bench for ddr_wr_line_packer: expected BRAM writes are queued at stimulus time.
module tb_ddr_wr_line_packer;
  import ddr_wb_pkg::*;

  logic                       clk;
  logic                       rst_n;
  logic [WORD_WIDTH-1:0]      s_data;
  logic                       s_valid;
  logic                       s_ready;
  logic                       flush;
  logic                       flush_done;
  logic [BRAM_ADDR_WIDTH-1:0] bram_wr_addr;
  logic [LINE_WIDTH-1:0]      bram_wr_din;
  logic                       bram_wr_en;
  logic                       bram_wr_we;
  logic                       line_rd_done;
  logic [CNT_WIDTH-1:0]       lines_avail;
  logic                       rd_underflow_err;

  typedef struct packed {
    logic [BRAM_ADDR_WIDTH-1:0] addr;
    logic [LINE_WIDTH-1:0]      data;
  } exp_wr_t;

  exp_wr_t                    sb_q[$];
  exp_wr_t                    mon_e;
  int                         errors   = 0;
  int                         checks   = 0;
  int                         n_writes = 0;

  logic [LINE_WIDTH-1:0]      m_line;
  int                         m_cnt;
  logic [BRAM_ADDR_WIDTH-1:0] m_ptr;
  int                         m_avail;
  logic                       m_uf;

  ddr_wr_line_packer dut (
    .c0_ddr4_ui_clk   (clk),
    .c0_ddr4_aresetn  (rst_n),
    .s_data           (s_data),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .flush            (flush),
    .flush_done       (flush_done),
    .bram_wr_addr     (bram_wr_addr),
    .bram_wr_din      (bram_wr_din),
    .bram_wr_en       (bram_wr_en),
    .bram_wr_we       (bram_wr_we),
    .line_rd_done     (line_rd_done),
    .lines_avail      (lines_avail),
    .rd_underflow_err (rd_underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every observed BRAM write must match the oldest queued line.
  always @(negedge clk) begin
    if (bram_wr_en === 1'b1) begin
      n_writes++;
      checks++;
      if (bram_wr_we !== 1'b1) begin
        errors++;
        $display("FAIL wr_we got=%b exp=1", bram_wr_we);
      end
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d", bram_wr_addr);
      end else begin
        mon_e = sb_q.pop_front();
        if (bram_wr_addr !== mon_e.addr || bram_wr_din !== mon_e.data) begin
          errors++;
          $display("FAIL wr_line addr got=%0d exp=%0d din got=%h exp=%h",
                   bram_wr_addr, mon_e.addr, bram_wr_din, mon_e.data);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_line  = '0;
    m_cnt   = 0;
    m_ptr   = '0;
    m_avail = 0;
    m_uf    = 1'b0;
  endtask

  task automatic push_line();
    sb_q.push_back('{addr: m_ptr, data: m_line});
    m_ptr   = m_ptr + 5'd1;
    m_cnt   = 0;
    m_line  = '0;
    m_avail = m_avail + 1;
  endtask

  task automatic model_accept(input logic [WORD_WIDTH-1:0] d, input logic f);
    m_line[m_cnt*WORD_WIDTH +: WORD_WIDTH] = d;
    m_cnt = m_cnt + 1;
    if (m_cnt == WORDS_PER_LINE) push_line();
    if (f && m_cnt > 0) push_line();
  endtask

  task automatic send_word(input logic [WORD_WIDTH-1:0] d, input logic f);
    int t;
    t       = 0;
    s_data  = d;
    s_valid = 1'b1;
    flush   = 1'b0;
    while (s_ready !== 1'b1 && t < 100) begin
      tick();
      t++;
    end
    flush = f;
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got=%b exp=1", s_ready);
    end else begin
      model_accept(d, f);
    end
    tick();
    flush = 1'b0;
  endtask

  task automatic send_line(input logic [WORD_WIDTH-1:0] base);
    for (int k = 0; k < WORDS_PER_LINE; k++) send_word(base + 64'(k), 1'b0);
    s_valid = 1'b0;
  endtask

  task automatic rd_pulse();
    line_rd_done = 1'b1;
    if (m_avail > 0) m_avail = m_avail - 1;
    else m_uf = 1'b1;
    tick();
    line_rd_done = 1'b0;
  endtask

  task automatic do_reset();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL pending_writes got=%0d exp=0", sb_q.size());
      sb_q.delete();
    end
    s_valid = 1'b0; flush = 1'b0; line_rd_done = 1'b0;
    rst_n = 1'b0;
    #13;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({s_ready, flush_done, bram_wr_en, bram_wr_we, bram_wr_addr, bram_wr_din,
         lines_avail, rd_underflow_err} !== '0) begin
      errors++;
      $display("FAIL %s got rdy=%b fd=%b en=%b we=%b addr=%0d avail=%0d uf=%b din_nz=%b exp=all0",
               name, s_ready, flush_done, bram_wr_en, bram_wr_we, bram_wr_addr,
               lines_avail, rd_underflow_err, |bram_wr_din);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; flush = 1'b0; line_rd_done = 1'b0; s_data = '0;
    model_reset();
    #7;
    check_all_zero("reset_outputs");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    checks++;
    if (s_ready !== 1'b1 || lines_avail !== 6'd0) begin
      errors++;
      $display("FAIL reset_release got rdy=%b avail=%0d exp rdy=1 avail=0", s_ready, lines_avail);
    end
  endtask

  task automatic test_single_line();
    for (int k = 1; k <= 8; k++) send_word(64'(k), 1'b0);
    checks++;
    if (bram_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL early_write got=%b exp=0", bram_wr_en);
    end
    send_word(64'd9, 1'b0);
    s_valid = 1'b0;
    checks++;
    if (bram_wr_en !== 1'b1 || lines_avail !== 6'd0) begin
      errors++;
      $display("FAIL line_write got en=%b avail=%0d exp en=1 avail=0", bram_wr_en, lines_avail);
    end
    tick();
    checks++;
    if (bram_wr_en !== 1'b0 || lines_avail !== 6'(m_avail)) begin
      errors++;
      $display("FAIL line_commit got en=%b avail=%0d exp en=0 avail=%0d", bram_wr_en, lines_avail, m_avail);
    end
  endtask

  task automatic test_fill_full();
    int n0;
    do_reset();
    for (int l = 0; l < DEPTH; l++) send_line(64'h1000 * 64'(l));
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready got=%b exp=0", s_ready);
    end
    tick(); tick();
    checks++;
    if (lines_avail !== 6'(m_avail)) begin
      errors++;
      $display("FAIL full_avail got=%0d exp=%0d", lines_avail, m_avail);
    end
    n0 = n_writes;
    s_valid = 1'b1; s_data = 64'hDEAD;
    tick(); tick(); tick();
    s_valid = 1'b0;
    checks++;
    if (n_writes != n0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_blocked got writes=%0d rdy=%b exp writes=0 rdy=0", n_writes - n0, s_ready);
    end
    rd_pulse();
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL credit_return_ready got=%b exp=1", s_ready);
    end
    send_line(64'h7700);
    tick(); tick();
    checks++;
    if (lines_avail !== 6'(m_avail)) begin
      errors++;
      $display("FAIL wrap_avail got=%0d exp=%0d", lines_avail, m_avail);
    end
    for (int l = 0; l < DEPTH; l++) rd_pulse();
    checks++;
    if (lines_avail !== 6'd0 || rd_underflow_err !== 1'b0) begin
      errors++;
      $display("FAIL drain got avail=%0d uf=%b exp avail=0 uf=0", lines_avail, rd_underflow_err);
    end
  endtask

  task automatic test_flush_partial();
    for (int k = 0; k < 4; k++) send_word(64'hA1 + 64'(k), 1'b0);
    s_valid = 1'b0;
    flush = 1'b1;
    if (m_cnt > 0) push_line();
    tick();
    checks++;
    if (flush_done !== 1'b1 || s_ready !== 1'b0 || bram_wr_en !== 1'b1) begin
      errors++;
      $display("FAIL flush_partial got fd=%b rdy=%b en=%b exp fd=1 rdy=0 en=1", flush_done, s_ready, bram_wr_en);
    end
    tick();
    flush = 1'b0;
    checks++;
    if (flush_done !== 1'b0 || s_ready !== 1'b1 || bram_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL flush_ignored got fd=%b rdy=%b en=%b exp fd=0 rdy=1 en=0", flush_done, s_ready, bram_wr_en);
    end
    send_line(64'hB0);
  endtask

  task automatic test_flush_empty();
    int n0;
    tick(); tick();
    n0 = n_writes;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (flush_done !== 1'b1) begin
      errors++;
      $display("FAIL flush_empty_done got=%b exp=1", flush_done);
    end
    tick(); tick();
    checks++;
    if (n_writes - n0 != 0) begin
      errors++;
      $display("FAIL flush_empty_writes got=%0d exp=0", n_writes - n0);
    end
    n0 = n_writes;
    for (int k = 0; k < 8; k++) send_word(64'hC0 + 64'(k), 1'b0);
    send_word(64'hC8, 1'b1);
    s_valid = 1'b0;
    checks++;
    if (flush_done !== 1'b1) begin
      errors++;
      $display("FAIL flush_last_done got=%b exp=1", flush_done);
    end
    tick(); tick(); tick();
    checks++;
    if (n_writes - n0 != 1) begin
      errors++;
      $display("FAIL flush_last_writes got=%0d exp=1", n_writes - n0);
    end
  endtask

  task automatic test_credit();
    do_reset();
    for (int l = 0; l < 5; l++) send_line(64'h5000 + 64'h10 * 64'(l));
    tick(); tick();
    checks++;
    if (lines_avail !== 6'd5) begin
      errors++;
      $display("FAIL avail_five got=%0d exp=5", lines_avail);
    end
    for (int k = 0; k < WORDS_PER_LINE; k++) send_word(64'h6000 + 64'(k), 1'b0);
    s_valid = 1'b0;
    rd_pulse();
    tick();
    checks++;
    if (lines_avail !== 6'(m_avail)) begin
      errors++;
      $display("FAIL avail_coincide got=%0d exp=%0d", lines_avail, m_avail);
    end
    for (int l = 0; l < 5; l++) rd_pulse();
    checks++;
    if (lines_avail !== 6'd0 || rd_underflow_err !== 1'b0) begin
      errors++;
      $display("FAIL pre_underflow got avail=%0d uf=%b exp avail=0 uf=0", lines_avail, rd_underflow_err);
    end
    rd_pulse();
    tick();
    checks++;
    if (lines_avail !== 6'd0 || rd_underflow_err !== m_uf || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL underflow got avail=%0d uf=%b rdy=%b exp avail=0 uf=%b rdy=1",
               lines_avail, rd_underflow_err, s_ready, m_uf);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_line(64'hC000);
    tick(); tick();
    for (int k = 0; k < 6; k++) send_word(64'hC100 + 64'(k), 1'b0);
    #1;
    rst_n = 1'b0;
    s_valid = 1'b0;
    #1;
    check_all_zero("reset_mid_line");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    send_line(64'hD000);
    tick(); tick();
    send_line(64'hE000);
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (flush_done !== 1'b1) begin
      errors++;
      $display("FAIL mid_flush_done got=%b exp=1", flush_done);
    end
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid_flush");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    send_line(64'hF000);
    tick(); tick(); tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL final_pending got=%0d exp=0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_fill_full();
    test_flush_partial();
    test_flush_empty();
    test_credit();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
